// File: rtl/mem_pkg.sv
// Shared types and elaboration helpers for the memory_dp slice.
package mem_pkg;

    typedef enum logic {CLEAR, READY} state_t;

    localparam int unsigned LEGAL_LAT [2] = '{1, 2};

    function automatic int unsigned lanes_of(input int unsigned data_width,
                                             input int unsigned lane_width);
        return data_width / lane_width;
    endfunction

    function automatic bit lat_is_legal(input int unsigned lat);
        return (lat == LEGAL_LAT[0]) || (lat == LEGAL_LAT[1]);
    endfunction

endpackage

// File: rtl/memory_dp_if.sv
// Write/read port bundle for memory_dp; MEM_PARITY_EN adds pinj and rerr.
interface memory_dp_if #(
    parameter int unsigned addr_width = 5,
    parameter int unsigned data_width = 16,
    parameter int unsigned lane_width = 8
);
    import mem_pkg::*;

    localparam int unsigned lanes = lanes_of(data_width, lane_width);

    logic                  wr;
    logic [addr_width-1:0] waddr;
    logic [data_width-1:0] wdata;
    logic [lanes-1:0]      wstrb;
    logic                  rd;
    logic [addr_width-1:0] raddr;
    logic [data_width-1:0] rdata;
    logic                  rvalid;
    logic                  busy;
`ifdef MEM_PARITY_EN
    logic                  pinj;
    logic                  rerr;

    modport master (output wr, waddr, wdata, wstrb, rd, raddr, pinj,
                    input  rdata, rvalid, busy, rerr);
    modport slave  (input  wr, waddr, wdata, wstrb, rd, raddr, pinj,
                    output rdata, rvalid, busy, rerr);
`else
    modport master (output wr, waddr, wdata, wstrb, rd, raddr,
                    input  rdata, rvalid, busy);
    modport slave  (input  wr, waddr, wdata, wstrb, rd, raddr,
                    output rdata, rvalid, busy);
`endif

endinterface

// File: rtl/memory_clear_fsm.sv
// Post-reset zeroing sweep: walks every address once, then releases busy.
module memory_clear_fsm #(
    parameter int unsigned addr_width = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  busy,
    output logic                  clr_we_c,
    output logic [addr_width-1:0] clr_addr
);
    import mem_pkg::*;

    state_t                state;
    logic [addr_width-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CLEAR;
            cnt   <= '0;
            busy  <= 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    cnt <= cnt + addr_width'(1);
                    // last address written this cycle; busy falls with it
                    if (cnt == '1) begin
                        state <= READY;
                        busy  <= 1'b0;
                    end
                end
                READY: busy <= 1'b0;
                default: begin
                    state <= CLEAR;
                    cnt   <= '0;
                    busy  <= 1'b1;
                end
            endcase
        end
    end

    assign clr_we_c = (state == CLEAR);
    assign clr_addr = cnt;

endmodule

// File: rtl/memory_dp.sv
// Dual-port (1W/1R) strobed memory with write-first bypass and clear sweep.
// Build option MEM_PARITY_EN: per-lane even parity with pinj/rerr.
module memory_dp #(
    parameter int unsigned addr_width = 5,
    parameter int unsigned data_width = 16,
    parameter int unsigned lane_width = 8,
    parameter int unsigned rd_latency = 1
) (
    input  logic        clk,
    input  logic        rst,
    memory_dp_if.slave  bus
);
    import mem_pkg::*;

    localparam int unsigned lanes = lanes_of(data_width, lane_width);
    localparam int unsigned depth = 2 ** addr_width;

    if (data_width % lane_width != 0) begin : g_bad_lane
        $error("memory_dp: data_width must be a multiple of lane_width");
    end
    if (!lat_is_legal(rd_latency)) begin : g_bad_lat
        $error("memory_dp: rd_latency must be 1 or 2");
    end

    logic                  busy_q;
    logic                  clr_we_c;
    logic [addr_width-1:0] clr_addr;

    memory_clear_fsm #(.addr_width(addr_width)) u_clear (
        .clk      (clk),
        .rst      (rst),
        .busy     (busy_q),
        .clr_we_c (clr_we_c),
        .clr_addr (clr_addr)
    );

    logic [data_width-1:0] mem [depth];
    logic                  wr_acc_c;
    logic                  rd_acc_c;
    logic                  same_addr_c;
    logic [data_width-1:0] rd_merged_c;

    assign wr_acc_c    = bus.wr & ~busy_q;
    assign rd_acc_c    = bus.rd & ~busy_q;
    assign same_addr_c = wr_acc_c && (bus.waddr == bus.raddr);

    // Write-first: strobed lanes of a colliding write override array contents
    always_comb begin
        rd_merged_c = mem[bus.raddr];
        for (int unsigned i = 0; i < lanes; i++) begin
            if (same_addr_c && bus.wstrb[i])
                rd_merged_c[i*lane_width +: lane_width] = bus.wdata[i*lane_width +: lane_width];
        end
    end

`ifdef MEM_PARITY_EN
    logic [lanes-1:0] par [depth];
    logic [lanes-1:0] wpar_c;
    logic [lanes-1:0] rd_par_c;
    logic             rd_perr_c;

    // Stored parity is even parity of the lane, optionally inverted by pinj
    always_comb begin
        wpar_c    = '0;
        rd_par_c  = par[bus.raddr];
        rd_perr_c = 1'b0;
        for (int unsigned i = 0; i < lanes; i++) begin
            wpar_c[i] = (^bus.wdata[i*lane_width +: lane_width]) ^ bus.pinj;
            if (same_addr_c && bus.wstrb[i])
                rd_par_c[i] = wpar_c[i];
            if ((^rd_merged_c[i*lane_width +: lane_width]) != rd_par_c[i])
                rd_perr_c = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr_we_c) begin
            par[clr_addr] <= '0;
        end else if (wr_acc_c) begin
            for (int unsigned i = 0; i < lanes; i++) begin
                if (bus.wstrb[i]) par[bus.waddr][i] <= wpar_c[i];
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (clr_we_c) begin
            mem[clr_addr] <= '0;
        end else if (wr_acc_c) begin
            for (int unsigned i = 0; i < lanes; i++) begin
                if (bus.wstrb[i])
                    mem[bus.waddr][i*lane_width +: lane_width] <= bus.wdata[i*lane_width +: lane_width];
            end
        end
    end

    logic                  rv1;
    logic [data_width-1:0] rd1;
    logic                  re1;

    // Array output register; rdata holds between reads
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rv1 <= 1'b0;
            rd1 <= '0;
            re1 <= 1'b0;
        end else begin
            rv1 <= rd_acc_c;
            if (rd_acc_c) rd1 <= rd_merged_c;
`ifdef MEM_PARITY_EN
            re1 <= rd_acc_c & rd_perr_c;
`else
            re1 <= 1'b0;
`endif
        end
    end

    logic                  rv_o;
    logic [data_width-1:0] rd_o;
    logic                  re_o;

    if (rd_latency == 2) begin : g_lat2
        logic                  rv2;
        logic [data_width-1:0] rd2;
        logic                  re2;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rv2 <= 1'b0;
                rd2 <= '0;
                re2 <= 1'b0;
            end else begin
                rv2 <= rv1;
                if (rv1) rd2 <= rd1;
                re2 <= re1;
            end
        end

        assign rv_o = rv2;
        assign rd_o = rd2;
        assign re_o = re2;
    end else begin : g_lat1
        assign rv_o = rv1;
        assign rd_o = rd1;
        assign re_o = re1;
    end

    assign bus.rvalid = rv_o;
    assign bus.rdata  = rd_o;
    assign bus.busy   = busy_q;
`ifdef MEM_PARITY_EN
    assign bus.rerr   = re_o;
`else
    logic unused_re;
    assign unused_re = re_o;
`endif

endmodule

// File: tb/tb_memory_dp.sv
// Bench for memory_dp: latency-1 and latency-2 instances driven in lockstep
// against a queue-based reference model; parity checks under MEM_PARITY_EN.
module tb_memory_dp;

    localparam int unsigned AW    = 5;
    localparam int unsigned DW    = 16;
    localparam int unsigned LW    = 8;
    localparam int unsigned LANES = 2;
    localparam int unsigned DEPTH = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic             d_rst, d_wr, d_rd, d_pinj;
    logic [AW-1:0]    d_waddr, d_raddr;
    logic [DW-1:0]    d_wdata;
    logic [LANES-1:0] d_wstrb;

    memory_dp_if #(.addr_width(AW), .data_width(DW), .lane_width(LW)) b1 ();
    memory_dp_if #(.addr_width(AW), .data_width(DW), .lane_width(LW)) b2 ();

    assign rst = d_rst;
    assign b1.wr = d_wr;  assign b1.waddr = d_waddr; assign b1.wdata = d_wdata;
    assign b1.wstrb = d_wstrb; assign b1.rd = d_rd; assign b1.raddr = d_raddr;
    assign b2.wr = d_wr;  assign b2.waddr = d_waddr; assign b2.wdata = d_wdata;
    assign b2.wstrb = d_wstrb; assign b2.rd = d_rd; assign b2.raddr = d_raddr;
`ifdef MEM_PARITY_EN
    assign b1.pinj = d_pinj;
    assign b2.pinj = d_pinj;
`endif

    memory_dp #(.addr_width(AW), .data_width(DW), .lane_width(LW), .rd_latency(1)) u_dut1 (
        .clk(clk), .rst(rst), .bus(b1.slave));
    memory_dp #(.addr_width(AW), .data_width(DW), .lane_width(LW), .rd_latency(2)) u_dut2 (
        .clk(clk), .rst(rst), .bus(b2.slave));

    // Reference model: memory image, sweep countdown, pending read results
    typedef struct {
        int            due;
        logic [DW-1:0] data;
        logic          err;
    } rd_t;

    logic [DW-1:0]    m_mem [DEPTH];
    logic [LANES-1:0] m_par [DEPTH];
    int               sweep_left;
    int               cyc;
    rd_t              q1[$];
    rd_t              q2[$];
    logic             e_v1, e_v2, e_busy;
    logic [DW-1:0]    e_d1, e_d2;
`ifdef MEM_PARITY_EN
    logic             e_e1, e_e2;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    task automatic model_edge();
        rd_t              r;
        logic [LANES-1:0] p;
        int               idx;
        e_v1 = 1'b0;
        e_v2 = 1'b0;
`ifdef MEM_PARITY_EN
        e_e1 = 1'b0;
        e_e2 = 1'b0;
`endif
        if (d_rst) begin
            sweep_left = DEPTH;
            q1.delete();
            q2.delete();
            e_d1 = '0;
            e_d2 = '0;
        end else begin
            if (sweep_left > 0) begin
                idx = DEPTH - sweep_left;
                m_mem[idx] = '0;
                m_par[idx] = '0;
                sweep_left--;
            end else begin
                if (d_rd) begin
                    r.data = m_mem[d_raddr];
                    p      = m_par[d_raddr];
                    for (int l = 0; l < LANES; l++) begin
                        if (d_wr && d_waddr == d_raddr && d_wstrb[l]) begin
                            r.data[l*LW +: LW] = d_wdata[l*LW +: LW];
                            p[l] = (^d_wdata[l*LW +: LW]) ^ d_pinj;
                        end
                    end
                    r.err = 1'b0;
                    for (int l = 0; l < LANES; l++)
                        if ((^r.data[l*LW +: LW]) != p[l]) r.err = 1'b1;
                    r.due = cyc;      q1.push_back(r);
                    r.due = cyc + 1;  q2.push_back(r);
                end
                if (d_wr) begin
                    for (int l = 0; l < LANES; l++) begin
                        if (d_wstrb[l]) begin
                            m_mem[d_waddr][l*LW +: LW] = d_wdata[l*LW +: LW];
                            m_par[d_waddr][l] = (^d_wdata[l*LW +: LW]) ^ d_pinj;
                        end
                    end
                end
            end
            if (q1.size() > 0 && q1[0].due == cyc) begin
                r = q1.pop_front();
                e_v1 = 1'b1; e_d1 = r.data;
`ifdef MEM_PARITY_EN
                e_e1 = r.err;
`endif
            end
            if (q2.size() > 0 && q2[0].due == cyc) begin
                r = q2.pop_front();
                e_v2 = 1'b1; e_d2 = r.data;
`ifdef MEM_PARITY_EN
                e_e2 = r.err;
`endif
            end
        end
        e_busy = d_rst || (sweep_left > 0);
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        d_wr = 1'b0; d_rd = 1'b0; d_pinj = 1'b0;
        d_waddr = '0; d_raddr = '0; d_wdata = '0; d_wstrb = '0;
    endtask

    task automatic test_reset();
        d_rst = 1'b1;
        idle_inputs();
        repeat (3) tick();
        n_chk++; if (b1.rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid1: got %b want 0", b1.rvalid); end
        n_chk++; if (b2.rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid2: got %b want 0", b2.rvalid); end
        n_chk++; if (b1.rdata !== 16'h0000) begin n_fail++; $display("FAIL reset_rdata1: got %h want 0000", b1.rdata); end
        n_chk++; if (b2.rdata !== 16'h0000) begin n_fail++; $display("FAIL reset_rdata2: got %h want 0000", b2.rdata); end
        n_chk++; if (b1.busy !== 1'b1 || b2.busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %b/%b want 1/1", b1.busy, b2.busy); end
    endtask

    task automatic test_clear();
        int busy_cycles = 0;
        d_rst = 1'b0; d_rd = 1'b1; d_raddr = '0;
        if (b1.busy === 1'b1) busy_cycles++;
        for (int i = 0; i < 40; i++) begin
            tick();
            n_chk++; if (b1.rvalid !== 1'b0 || b2.rvalid !== 1'b0) begin n_fail++; $display("FAIL clear_no_rvalid: got %b/%b want 0/0 at step %0d", b1.rvalid, b2.rvalid, i); end
            n_chk++; if (b1.busy !== e_busy || b2.busy !== e_busy) begin n_fail++; $display("FAIL clear_busy: got %b/%b want %b at step %0d", b1.busy, b2.busy, e_busy, i); end
            if (b1.busy !== 1'b1) break;
            busy_cycles++;
        end
        d_rd = 1'b0;
        n_chk++; if (busy_cycles != DEPTH) begin n_fail++; $display("FAIL clear_busy_len: got %0d want %0d", busy_cycles, DEPTH); end
        d_rd = 1'b1; d_raddr = 5'd31;
        tick();
        d_rd = 1'b0;
        n_chk++; if (b1.rvalid !== 1'b1 || b1.rdata !== 16'h0000) begin n_fail++; $display("FAIL clear_read31_l1: got v=%b d=%h want v=1 d=0000", b1.rvalid, b1.rdata); end
        tick();
        n_chk++; if (b2.rvalid !== 1'b1 || b2.rdata !== 16'h0000) begin n_fail++; $display("FAIL clear_read31_l2: got v=%b d=%h want v=1 d=0000", b2.rvalid, b2.rdata); end
    endtask

    task automatic test_write_read();
        d_wr = 1'b1; d_waddr = 5'd0;  d_wdata = 16'hFFFF; d_wstrb = 2'b11;
        tick();
        d_waddr = 5'd31; d_wdata = 16'h0000;
        tick();
        d_wr = 1'b0; d_rd = 1'b1; d_raddr = 5'd0;
        tick();
        n_chk++; if (b1.rvalid !== 1'b1 || b1.rdata !== 16'hFFFF) begin n_fail++; $display("FAIL wr_rd0_l1: got v=%b d=%h want v=1 d=ffff", b1.rvalid, b1.rdata); end
        n_chk++; if (b2.rvalid !== 1'b0) begin n_fail++; $display("FAIL wr_rd0_l2_early: got v=%b want 0", b2.rvalid); end
        d_raddr = 5'd31;
        tick();
        n_chk++; if (b1.rvalid !== 1'b1 || b1.rdata !== 16'h0000) begin n_fail++; $display("FAIL wr_rd31_l1: got v=%b d=%h want v=1 d=0000", b1.rvalid, b1.rdata); end
        n_chk++; if (b2.rvalid !== 1'b1 || b2.rdata !== 16'hFFFF) begin n_fail++; $display("FAIL wr_rd0_l2: got v=%b d=%h want v=1 d=ffff", b2.rvalid, b2.rdata); end
        d_rd = 1'b0;
        tick();
        n_chk++; if (b1.rvalid !== 1'b0 || b1.rdata !== 16'h0000) begin n_fail++; $display("FAIL wr_rd_hold_l1: got v=%b d=%h want v=0 d=0000", b1.rvalid, b1.rdata); end
        n_chk++; if (b2.rvalid !== 1'b1 || b2.rdata !== 16'h0000) begin n_fail++; $display("FAIL wr_rd31_l2: got v=%b d=%h want v=1 d=0000", b2.rvalid, b2.rdata); end
    endtask

    task automatic test_strobe();
        d_wr = 1'b1; d_waddr = 5'd3; d_wdata = 16'hABCD; d_wstrb = 2'b01;
        tick();
        d_wr = 1'b0; d_rd = 1'b1; d_raddr = 5'd3;
        tick();
        d_rd = 1'b0;
        n_chk++; if (b1.rvalid !== 1'b1 || b1.rdata !== 16'h00CD) begin n_fail++; $display("FAIL strobe_lane0: got v=%b d=%h want v=1 d=00cd", b1.rvalid, b1.rdata); end
        d_wr = 1'b1; d_wstrb = 2'b00; d_wdata = 16'hFFFF;
        tick();
        d_wr = 1'b0; d_rd = 1'b1;
        tick();
        d_rd = 1'b0;
        n_chk++; if (b1.rvalid !== 1'b1 || b1.rdata !== 16'h00CD) begin n_fail++; $display("FAIL strobe_none: got v=%b d=%h want v=1 d=00cd", b1.rvalid, b1.rdata); end
        tick();
    endtask

    task automatic test_bypass();
        d_wr = 1'b1; d_waddr = 5'd7; d_wdata = 16'h5678; d_wstrb = 2'b11;
        tick();
        d_wdata = 16'h1234; d_wstrb = 2'b10; d_rd = 1'b1; d_raddr = 5'd7;
        tick();
        d_wr = 1'b0;
        n_chk++; if (b1.rvalid !== 1'b1 || b1.rdata !== 16'h1278) begin n_fail++; $display("FAIL bypass_l1: got v=%b d=%h want v=1 d=1278", b1.rvalid, b1.rdata); end
        tick();
        d_rd = 1'b0;
        n_chk++; if (b2.rvalid !== 1'b1 || b2.rdata !== 16'h1278) begin n_fail++; $display("FAIL bypass_l2: got v=%b d=%h want v=1 d=1278", b2.rvalid, b2.rdata); end
        n_chk++; if (b1.rvalid !== 1'b1 || b1.rdata !== 16'h1278) begin n_fail++; $display("FAIL bypass_stored: got v=%b d=%h want v=1 d=1278", b1.rvalid, b1.rdata); end
        tick();
    endtask

    task automatic test_back_to_back();
        int v2_count = 0;
        for (int i = 0; i <= 30; i++) begin
            d_wr = 1'b1; d_waddr = AW'(31 - i); d_wdata = DW'(i); d_wstrb = 2'b11;
            tick();
        end
        d_wr = 1'b0;
        for (int t = 0; t <= 32; t++) begin
            d_rd = (t < 31); d_raddr = AW'(t + 1);
            tick();
            n_chk++;
            if (b1.rvalid !== (t < 31) || ((t < 31) && b1.rdata !== DW'(30 - t))) begin
                n_fail++; $display("FAIL b2b_l1 t=%0d: got v=%b d=%h want v=%b d=%h", t, b1.rvalid, b1.rdata, (t < 31), DW'(30 - t));
            end
            n_chk++;
            if (b2.rvalid !== (t >= 1 && t <= 31) || ((t >= 1 && t <= 31) && b2.rdata !== DW'(31 - t))) begin
                n_fail++; $display("FAIL b2b_l2 t=%0d: got v=%b d=%h want v=%b d=%h", t, b2.rvalid, b2.rdata, (t >= 1 && t <= 31), DW'(31 - t));
            end
            if (b2.rvalid === 1'b1) v2_count++;
        end
        n_chk++; if (v2_count != 31) begin n_fail++; $display("FAIL b2b_l2_count: got %0d want 31", v2_count); end
    endtask

`ifdef MEM_PARITY_EN
    task automatic test_parity();
        d_wr = 1'b1; d_waddr = 5'd5; d_wdata = 16'h00FF; d_wstrb = 2'b11; d_pinj = 1'b1;
        tick();
        d_pinj = 1'b0; d_waddr = 5'd6; d_wdata = 16'h1357;
        tick();
        d_wr = 1'b0; d_rd = 1'b1; d_raddr = 5'd5;
        tick();
        n_chk++; if (b1.rvalid !== 1'b1 || b1.rerr !== 1'b1) begin n_fail++; $display("FAIL parity_inj_l1: got v=%b e=%b want 1/1", b1.rvalid, b1.rerr); end
        d_raddr = 5'd6;
        tick();
        n_chk++; if (b1.rvalid !== 1'b1 || b1.rerr !== 1'b0) begin n_fail++; $display("FAIL parity_clean_l1: got v=%b e=%b want 1/0", b1.rvalid, b1.rerr); end
        n_chk++; if (b2.rvalid !== 1'b1 || b2.rerr !== 1'b1) begin n_fail++; $display("FAIL parity_inj_l2: got v=%b e=%b want 1/1", b2.rvalid, b2.rerr); end
        d_rd = 1'b1; d_wr = 1'b1; d_waddr = 5'd6; d_raddr = 5'd6; d_wstrb = 2'b01; d_pinj = 1'b1;
        tick();
        d_wr = 1'b0; d_rd = 1'b0; d_pinj = 1'b0;
        n_chk++; if (b1.rvalid !== 1'b1 || b1.rerr !== 1'b1) begin n_fail++; $display("FAIL parity_bypass: got v=%b e=%b want 1/1", b1.rvalid, b1.rerr); end
        tick();
        tick();
        n_chk++; if (b1.rerr !== 1'b0 || b2.rerr !== 1'b0) begin n_fail++; $display("FAIL parity_idle: got %b/%b want 0/0", b1.rerr, b2.rerr); end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            d_wr    = 1'($urandom_range(0, 1));
            d_rd    = 1'($urandom_range(0, 1));
            d_waddr = AW'($urandom_range(0, 7));
            d_raddr = AW'($urandom_range(0, 7));
            d_wdata = DW'($urandom);
            d_wstrb = LANES'($urandom_range(0, 3));
`ifdef MEM_PARITY_EN
            d_pinj  = ($urandom_range(0, 7) == 0);
`endif
            tick();
            n_chk++; if (b1.rvalid !== e_v1 || b1.rdata !== e_d1) begin n_fail++; $display("FAIL rand_l1 i=%0d: got v=%b d=%h want v=%b d=%h", i, b1.rvalid, b1.rdata, e_v1, e_d1); end
            n_chk++; if (b2.rvalid !== e_v2 || b2.rdata !== e_d2) begin n_fail++; $display("FAIL rand_l2 i=%0d: got v=%b d=%h want v=%b d=%h", i, b2.rvalid, b2.rdata, e_v2, e_d2); end
`ifdef MEM_PARITY_EN
            n_chk++; if (b1.rerr !== e_e1 || b2.rerr !== e_e2) begin n_fail++; $display("FAIL rand_rerr i=%0d: got %b/%b want %b/%b", i, b1.rerr, b2.rerr, e_e1, e_e2); end
`endif
        end
        idle_inputs();
        repeat (2) tick();
    endtask

    task automatic test_reset_midflight();
        int busy_cycles = 0;
        d_rd = 1'b1; d_raddr = 5'd1;
        tick();
        d_raddr = 5'd2;
        tick();
        d_rst = 1'b1; d_rd = 1'b0;
        #1;
        n_chk++; if (b1.rvalid !== 1'b0 || b2.rvalid !== 1'b0) begin n_fail++; $display("FAIL midrst_async: got %b/%b want 0/0", b1.rvalid, b2.rvalid); end
        repeat (2) begin
            tick();
            n_chk++; if (b1.rvalid !== 1'b0 || b2.rvalid !== 1'b0 || b1.busy !== 1'b1) begin n_fail++; $display("FAIL midrst_hold: got v=%b/%b busy=%b want 0/0 busy=1", b1.rvalid, b2.rvalid, b1.busy); end
        end
        d_rst = 1'b0; d_rd = 1'b1; d_raddr = 5'd4;
        if (b2.busy === 1'b1) busy_cycles++;
        for (int i = 0; i < 40; i++) begin
            tick();
            n_chk++; if (b1.rvalid !== 1'b0 || b2.rvalid !== 1'b0) begin n_fail++; $display("FAIL midrst_no_rvalid: got %b/%b want 0/0 at step %0d", b1.rvalid, b2.rvalid, i); end
            if (b2.busy !== 1'b1) break;
            busy_cycles++;
        end
        d_rd = 1'b0;
        n_chk++; if (busy_cycles != DEPTH) begin n_fail++; $display("FAIL midrst_busy_len: got %0d want %0d", busy_cycles, DEPTH); end
        d_rd = 1'b1; d_raddr = 5'd7;
        tick();
        d_rd = 1'b0;
        n_chk++; if (b1.rvalid !== 1'b1 || b1.rdata !== 16'h0000) begin n_fail++; $display("FAIL midrst_swept: got v=%b d=%h want v=1 d=0000", b1.rvalid, b1.rdata); end
        tick();
    endtask

    initial begin
        cyc = 0;
        sweep_left = DEPTH;
        q1.delete();
        q2.delete();
        e_d1 = '0; e_d2 = '0; e_v1 = 1'b0; e_v2 = 1'b0; e_busy = 1'b1;
`ifdef MEM_PARITY_EN
        e_e1 = 1'b0; e_e2 = 1'b0;
`endif
        for (int a = 0; a < DEPTH; a++) begin
            m_mem[a] = '0;
            m_par[a] = '0;
        end
        test_reset();
        test_clear();
        test_write_read();
        test_strobe();
        test_bypass();
        test_back_to_back();
`ifdef MEM_PARITY_EN
        test_parity();
`endif
        test_random();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
